dut_cmd_sequencer: RTL
======================

Name: dut_cmd_sequencer

Overview:
- Command front-end between the virtual slave bus and a processor core inside dut_top.
- Decodes slave-bus register writes into 32-bit commands and queues them in a small FIFO.
- Issues queued commands one at a time to the core over a valid/ready handshake and waits for completion.
- Generates BUSY, a maskable INTR, and a readable status/completion count.

Parameters:
- C_ADDR_BITS, 16: slave bus address width (matches S_WADDR/S_RADDR).
- C_FIFO_DEPTH_BITS, 2: log2 of command FIFO depth (default depth 4).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- nRST  input  1  synchronous reset, active-low.
- S_WE  input  1  slave write strobe.
- S_WADDR  input  C_ADDR_BITS  slave write word address.
- S_WDATA  input  32  slave write data.
- S_RE  input  1  slave read strobe.
- S_RADDR  input  C_ADDR_BITS  slave read word address.
- S_RDATA  output  32  slave read data, registered.
- CMD_VALID  output  1  command offered to core.
- CMD_READY  input  1  core accepts command.
- CMD_DATA  output  32  command word (FIFO head).
- CORE_DONE  input  1  single-cycle pulse: core finished the current command.
- BUSY  output  1  sequencer has work pending or in flight.
- INTR  output  1  level interrupt.

Behaviour:
- Clock and reset: one clock (CLK). Reset is synchronous, active-low (nRST).
- Reset values: S_RDATA=0, CMD_VALID=0, BUSY=0, INTR=0. FIFO empty, state IDLE, all registers and counters 0.
- Reset asserted mid-operation: the in-flight command is abandoned, FIFO contents are discarded, and CMD_VALID is 0 after the reset edge.
- Register map (word address; any address with upper bits nonzero or offset >4 is unmapped):
  - 0 CMD (W): push S_WDATA into FIFO.
  - 1 STATUS (R): [0] busy, [1] intr_pending, [2] overflow, [3] fifo_full, [7:4] fifo_count (zero-extended), others 0.
  - 2 INTR_CLR (W): bit0=1 clears intr_pending; bit1=1 clears overflow.
  - 3 INTR_EN (RW): bit0 = interrupt enable; read returns {31'b0,en}.
  - 4 DONE_CNT (RW): 16-bit completion counter, zero-extended on read. Any write resets it to 0.
- Unmapped reads return 0. Unmapped writes are ignored.
- Read latency: S_RDATA is updated on the edge where S_RE=1 and holds its value otherwise. A read of STATUS reflects state before that edge's updates.
- FIFO push rule: a CMD write is accepted if not full, or if full and a pop occurs in the same cycle.
- Otherwise the write is dropped and the sticky overflow bit is set.
- FIFO pointers wrap modulo depth. fifo_count range is 0..depth.
- FSM:
  - IDLE: if FIFO not empty -> ISSUE.
  - ISSUE: CMD_VALID=1, CMD_DATA=FIFO head, held stable until CMD_READY. On CMD_VALID&CMD_READY, pop FIFO -> WAIT.
  - WAIT: CMD_VALID=0. On CORE_DONE, DONE_CNT+=1 (wraps 0xFFFF->0) and intr_pending is set if INTR_EN[0]. Then -> ISSUE if FIFO (after this cycle's push) is not empty, else -> IDLE.
- CORE_DONE outside WAIT is ignored.
- Minimum spacing between accepted commands: ISSUE, WAIT(done), ISSUE, i.e. one idle cycle of CMD_VALID between commands.
- BUSY = (state != IDLE) | (fifo_count != 0), registered (reflects state after the edge).
- INTR = intr_pending & INTR_EN[0]. Clearing INTR_EN masks INTR but does not clear pending.
- Simultaneous events:
  - CORE_DONE set and INTR_CLR bit0 in the same cycle: set wins.
  - DONE_CNT write and CORE_DONE in the same cycle: the write wins (result 0).
  - S_WE and S_RE to the same register in the same cycle: the read returns the old value.

Test Plan:
- Reset, then read STATUS -> S_RDATA=0 one cycle after S_RE; BUSY=0, INTR=0, CMD_VALID=0.
- INTR_EN=1; write CMD=0x12345678; CMD_READY=1, CORE_DONE pulse 3 cycles after accept -> CMD_DATA=0x12345678 with CMD_VALID for exactly 1 cycle; DONE_CNT=1; INTR=1; BUSY falls after done. Write INTR_CLR=1 -> INTR=0.
- CMD_READY=0; write 5 commands (0xA0..0xA4) -> STATUS=0x4D (count 4, full, overflow, busy). Release READY with CORE_DONE each -> core receives 0xA0..0xA3 in order; DONE_CNT=4.
- FIFO full in ISSUE; CMD write in the same cycle as CMD_READY -> write accepted, overflow stays 0, fifo_count remains 4.
- CORE_DONE with INTR_CLR bit0 in the same cycle -> intr_pending remains 1. CORE_DONE while IDLE -> DONE_CNT unchanged.
- nRST low for 1 cycle while in WAIT with 2 commands queued -> next cycle CMD_VALID=0, BUSY=0, STATUS=0, DONE_CNT=0.

Source files
------------

// File: rtl/dut_cmd_sequencer.sv
// Command sequencer: slave-bus register front-end, command FIFO,
// and a valid/ready issue engine that waits for core completion.
module dut_cmd_sequencer #(
  parameter int C_ADDR_BITS       = 16,
  parameter int C_FIFO_DEPTH_BITS = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   S_WE,
  input  logic [C_ADDR_BITS-1:0] S_WADDR,
  input  logic [31:0]            S_WDATA,
  input  logic                   S_RE,
  input  logic [C_ADDR_BITS-1:0] S_RADDR,
  output logic [31:0]            S_RDATA,
  output logic                   CMD_VALID,
  input  logic                   CMD_READY,
  output logic [31:0]            CMD_DATA,
  input  logic                   CORE_DONE,
  output logic                   BUSY,
  output logic                   INTR
);

  localparam int DB    = C_FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << DB;
  localparam int CW    = DB + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state, state_nx;

  logic [31:0]   mem [DEPTH];
  logic [DB-1:0] wp, rp;
  logic [CW-1:0] count, count_nx;
  logic          full, push, pop, done_ev;

  logic          busy_q, pend, ovf, en;
  logic [15:0]   done_cnt;
  logic [31:0]   rdata;

  logic wr_cmd, wr_clr, wr_en, wr_done;
  logic rd_status, rd_en, rd_done;

  assign wr_cmd  = S_WE && (S_WADDR == C_ADDR_BITS'(0));
  assign wr_clr  = S_WE && (S_WADDR == C_ADDR_BITS'(2));
  assign wr_en   = S_WE && (S_WADDR == C_ADDR_BITS'(3));
  assign wr_done = S_WE && (S_WADDR == C_ADDR_BITS'(4));

  assign rd_status = S_RADDR == C_ADDR_BITS'(1);
  assign rd_en     = S_RADDR == C_ADDR_BITS'(3);
  assign rd_done   = S_RADDR == C_ADDR_BITS'(4);

  assign full     = count == CW'(DEPTH);
  assign pop      = (state == ISSUE) && CMD_READY;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign push     = wr_cmd && (!full || pop);
  assign count_nx = count + CW'(push) - CW'(pop);
  assign done_ev  = (state == WAIT) && CORE_DONE;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (count != '0) state_nx = ISSUE;
      ISSUE: if (CMD_READY) state_nx = WAIT;
      WAIT:
        if (CORE_DONE)
          state_nx = (count_nx != '0) ? ISSUE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd_status: rdata = {24'b0, 4'(count), full, ovf, pend, busy_q};
      rd_en:     rdata = {31'b0, en};
      rd_done:   rdata = {16'b0, done_cnt};
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= S_WDATA;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      pend     <= 1'b0;
      ovf      <= 1'b0;
      en       <= 1'b0;
      done_cnt <= '0;
      S_RDATA  <= '0;
    end else begin
      state  <= state_nx;
      count  <= count_nx;
      busy_q <= (state_nx != IDLE) || (count_nx != '0);
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (wr_cmd && !push) ovf <= 1'b1;
      else if (wr_clr && S_WDATA[1]) ovf <= 1'b0;
      if (done_ev && en) pend <= 1'b1;
      else if (wr_clr && S_WDATA[0]) pend <= 1'b0;
      if (wr_en) en <= S_WDATA[0];
      if (wr_done) done_cnt <= '0;
      else if (done_ev) done_cnt <= done_cnt + 16'd1;
      if (S_RE) S_RDATA <= rdata;
    end
  end

  assign CMD_VALID = state == ISSUE;
  assign CMD_DATA  = mem[rp];
  assign BUSY      = busy_q;
  assign INTR      = pend && en;

endmodule
